// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage.
// MEM has priority; a saturating starvation counter forces an IF grant so fetch always progresses.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   // instruction fetch port
   input  logic              ifreq,
   input  logic [ADDR_W-1:0] ifaddr,
   output logic [DATA_W-1:0] ifrdata,
   output logic              ifvalid,
   output logic              stallif,
   // data port
   input  logic              memrd,
   input  logic              memwr,
   input  logic [ADDR_W-1:0] memaddr,
   input  logic [DATA_W-1:0] memwdata,
   output logic [DATA_W-1:0] memrdata,
   output logic              memvalid,
   output logic              stallmem,
   // memory side
   output logic              ramreq,
   output logic              ramwe,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramwdata,
   input  logic [DATA_W-1:0] ramrdata,
   input  logic              ramack
);

   // Out-of-range settings are clamped so the 4-bit counter can always reach the limit.
   localparam int STARVE_CLAMP = (STARVE_MAX < 1) ? 1 : ((STARVE_MAX > 15) ? 15 : STARVE_MAX);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_CLAMP);

   localparam int P_IF  = 0;
   localparam int P_MEM = 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IF  = 2'd1,
      BUSY_MEM = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [3:0]          starve_reg, starve_next;
   logic                ramreq_reg, ramreq_next;
   logic                ramwe_reg, ramwe_next;
   logic [ADDR_W-1:0]   ramaddr_reg, ramaddr_next;
   logic [DATA_W-1:0]   ramwdata_reg, ramwdata_next;

   logic                mem_req;
   logic                if_forced;
   logic                mem_win;
   logic [1:0]          port_req;
   logic [1:0]          port_owner;
   logic [1:0]          port_valid;
   logic [1:0]          port_stall;

   assign mem_req   = memrd | memwr;
   assign if_forced = ifreq & (starve_reg >= STARVE_LIM);
   assign mem_win   = mem_req & ~if_forced;

   assign port_req[P_IF]    = ifreq;
   assign port_req[P_MEM]   = mem_req;
   assign port_owner[P_IF]  = (state_reg == BUSY_IF);
   assign port_owner[P_MEM] = (state_reg == BUSY_MEM);

   // Completion and stall are the same per-port function of ownership and request.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         assign port_valid[gi] = ramack & port_owner[gi];
         assign port_stall[gi] = port_req[gi] & ~port_valid[gi];
      end
   endgenerate

   assign ifvalid  = port_valid[P_IF];
   assign memvalid = port_valid[P_MEM];
   assign stallif  = port_stall[P_IF];
   assign stallmem = port_stall[P_MEM];

   assign ifrdata  = ramrdata;
   assign memrdata = ramrdata;

   assign ramreq   = ramreq_reg;
   assign ramwe    = ramwe_reg;
   assign ramaddr  = ramaddr_reg;
   assign ramwdata = ramwdata_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         starve_reg   <= '0;
         ramreq_reg   <= 1'b0;
         ramwe_reg    <= 1'b0;
         ramaddr_reg  <= '0;
         ramwdata_reg <= '0;
      end else begin
         state_reg    <= state_next;
         starve_reg   <= starve_next;
         ramreq_reg   <= ramreq_next;
         ramwe_reg    <= ramwe_next;
         ramaddr_reg  <= ramaddr_next;
         ramwdata_reg <= ramwdata_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      starve_next   = starve_reg;
      ramreq_next   = ramreq_reg;
      ramwe_next    = ramwe_reg;
      ramaddr_next  = ramaddr_reg;
      ramwdata_next = ramwdata_reg;

      // A fetch that is not waiting cannot be starved.
      if (!ifreq) begin
         starve_next = '0;
      end

      case (state_reg)
         IDLE: begin
            ramreq_next = 1'b0;
            if (mem_win) begin
               state_next    = BUSY_MEM;
               ramreq_next   = 1'b1;
               ramwe_next    = memwr;
               ramaddr_next  = memaddr;
               ramwdata_next = memwdata;
               if (ifreq && (starve_reg < STARVE_LIM)) begin
                  starve_next = starve_reg + 4'd1;
               end
            end else if (ifreq) begin
               state_next   = BUSY_IF;
               ramreq_next  = 1'b1;
               ramwe_next   = 1'b0;
               ramaddr_next = ifaddr;
               starve_next  = '0;
            end
         end
         BUSY_IF, BUSY_MEM: begin
            if (ramack) begin
               state_next  = IDLE;
               ramreq_next = 1'b0;
            end
         end
         default: begin
            state_next  = IDLE;
            ramreq_next = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: queued requesters, a variable-latency memory model,
// and a monitor that checks each completion against the expected grant order.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        ifreq;
   logic [31:0] ifaddr;
   logic [31:0] ifrdata;
   logic        ifvalid;
   logic        stallif;
   logic        memrd;
   logic        memwr;
   logic [31:0] memaddr;
   logic [31:0] memwdata;
   logic [31:0] memrdata;
   logic        memvalid;
   logic        stallmem;
   logic        ramreq;
   logic        ramwe;
   logic [31:0] ramaddr;
   logic [31:0] ramwdata;
   logic [31:0] ramrdata;
   logic        ramack;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .ifreq    (ifreq),
      .ifaddr   (ifaddr),
      .ifrdata  (ifrdata),
      .ifvalid  (ifvalid),
      .stallif  (stallif),
      .memrd    (memrd),
      .memwr    (memwr),
      .memaddr  (memaddr),
      .memwdata (memwdata),
      .memrdata (memrdata),
      .memvalid (memvalid),
      .stallmem (stallmem),
      .ramreq   (ramreq),
      .ramwe    (ramwe),
      .ramaddr  (ramaddr),
      .ramwdata (ramwdata),
      .ramrdata (ramrdata),
      .ramack   (ramack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        port;   // 0 = IF, 1 = MEM
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mop_t;

   exp_t        sb[$];
   logic [31:0] if_q[$];
   mop_t        mem_q[$];
   int          n_tests;
   int          n_fail;
   int          mem_lat;
   bit          stray_ack;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h40) ? 32'h8C22_0004 : (a ^ 32'hA5A5_0F0F);
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_if(input logic [31:0] a);
      exp_t e;
      e = '{port: 1'b0, we: 1'b0, addr: a, wdata: 32'h0, rdata: mem_data(a)};
      if_q.push_back(a);
      sb.push_back(e);
   endtask

   task automatic push_mem(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      mop_t m;
      m = '{rd: rd, wr: wr, addr: a, wdata: d};
      e = '{port: 1'b1, we: wr, addr: a, wdata: d, rdata: mem_data(a)};
      mem_q.push_back(m);
      sb.push_back(e);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((sb.size() > 0 || if_q.size() > 0 || mem_q.size() > 0 || ifreq || memrd || memwr) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_drained"}, 64'(n < 300), 64'd1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      ifreq = 1'b0; ifaddr = '0;
      memrd = 1'b0; memwr = 1'b0; memaddr = '0; memwdata = '0;
      ramrdata = '0; ramack = 1'b0;
      n_tests = 0; n_fail = 0; mem_lat = 0; stray_ack = 1'b0;

      fork
         begin : watchdog
            #200000;
            $display("FAIL watchdog: simulation exceeded time limit");
            $fatal(1, "watchdog");
         end
         begin : mem_model
            int wait_cnt;
            wait_cnt = 0;
            forever begin
               @(posedge clk); #2;
               ramack = 1'b0;
               if (stray_ack) begin
                  ramack = 1'b1; ramrdata = 32'h1234_5678; stray_ack = 1'b0; wait_cnt = 0;
               end else if (rst || !ramreq) begin
                  wait_cnt = 0;
               end else if (wait_cnt >= mem_lat) begin
                  ramack = 1'b1; ramrdata = mem_data(ramaddr); wait_cnt = 0;
               end else begin
                  wait_cnt++;
               end
            end
         end
         begin : if_driver
            bit done;
            done = 1'b0;
            forever begin
               @(posedge clk); #1;
               if (done && if_q.size() > 0) void'(if_q.pop_front());
               if (if_q.size() > 0) begin ifreq = 1'b1; ifaddr = if_q[0]; end
               else ifreq = 1'b0;
               @(negedge clk);
               done = ifvalid;
            end
         end
         begin : mem_driver
            bit done;
            done = 1'b0;
            forever begin
               @(posedge clk); #1;
               if (done && mem_q.size() > 0) void'(mem_q.pop_front());
               if (mem_q.size() > 0) begin
                  memrd = mem_q[0].rd; memwr = mem_q[0].wr;
                  memaddr = mem_q[0].addr; memwdata = mem_q[0].wdata;
               end else begin
                  memrd = 1'b0; memwr = 1'b0;
               end
               @(negedge clk);
               done = memvalid;
            end
         end
         begin : monitor
            logic        prev_req, prev_valid, prev_we;
            logic [31:0] prev_addr, prev_wdata;
            exp_t        e;
            prev_req = 0; prev_valid = 0; prev_we = 0; prev_addr = 0; prev_wdata = 0;
            forever begin
               @(negedge clk);
               if (!rst) begin
                  chk("stallif", 64'(stallif), 64'(ifreq & ~ifvalid));
                  chk("stallmem", 64'(stallmem), 64'((memrd | memwr) & ~memvalid));
                  if (ifvalid && memvalid) chk("dual_valid", 64'd1, 64'd0);
                  if (prev_valid) chk("ramreq_drop", 64'(ramreq), 64'd0);
                  if (ramreq && prev_req && !prev_valid) begin
                     chk("hold_addr", 64'(ramaddr), 64'(prev_addr));
                     chk("hold_we", 64'(ramwe), 64'(prev_we));
                     chk("hold_wdata", 64'(ramwdata), 64'(prev_wdata));
                  end
                  if (ifvalid || memvalid) begin
                     if (sb.size() == 0) begin
                        chk("unexpected_valid", {63'd0, memvalid}, 64'hFFFF);
                     end else begin
                        e = sb.pop_front();
                        $display("[TB] %0t done port=%s we=%0b addr=%h", $time, memvalid ? "MEM" : "IF", ramwe, ramaddr);
                        chk("grant_port", 64'(memvalid), 64'(e.port));
                        chk("ram_req", 64'(ramreq), 64'd1);
                        chk("ram_we", 64'(ramwe), 64'(e.we));
                        chk("ram_addr", 64'(ramaddr), 64'(e.addr));
                        if (e.we) chk("ram_wdata", 64'(ramwdata), 64'(e.wdata));
                        else if (e.port) chk("memrdata", 64'(memrdata), 64'(e.rdata));
                        else chk("ifrdata", 64'(ifrdata), 64'(e.rdata));
                     end
                  end
                  prev_req = ramreq; prev_valid = ifvalid | memvalid;
                  prev_we = ramwe; prev_addr = ramaddr; prev_wdata = ramwdata;
               end else begin
                  prev_req = 0; prev_valid = 0;
               end
            end
         end
      join_none

      // Reset values and combinational stalls while in reset
      @(negedge clk);
      chk("rst_ramreq", 64'(ramreq), 64'd0);
      chk("rst_ramwe", 64'(ramwe), 64'd0);
      chk("rst_ramaddr", 64'(ramaddr), 64'd0);
      chk("rst_ramwdata", 64'(ramwdata), 64'd0);
      chk("rst_ifvalid", 64'(ifvalid), 64'd0);
      chk("rst_memvalid", 64'(memvalid), 64'd0);
      ifreq = 1'b1; memwr = 1'b1; #1;
      chk("rst_stallif", 64'(stallif), 64'd1);
      chk("rst_stallmem", 64'(stallmem), 64'd1);
      ifreq = 1'b0; memwr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single fetch, memory acks two cycles after the request appears
      mem_lat = 2;
      push_if(32'h40);
      @(posedge clk); #3;
      chk("t1_no_req_yet", 64'(ramreq), 64'd0);
      chk("t1_stall_c0", 64'(stallif), 64'd1);
      @(posedge clk); #3;
      chk("t1_ramreq", 64'(ramreq), 64'd1);
      chk("t1_ramwe", 64'(ramwe), 64'd0);
      chk("t1_ramaddr", 64'(ramaddr), 64'h40);
      drain("t1");

      // Simultaneous IF and MEM read with immediate acks: MEM first, then IF
      mem_lat = 0;
      push_mem(1'b1, 1'b0, 32'h100, 32'h0);
      push_if(32'h44);
      drain("t2");

      // Store held until a late ack, then a read+write combination treated as a write
      mem_lat = 3;
      push_mem(1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF);
      drain("t3a");
      mem_lat = 1;
      push_mem(1'b1, 1'b1, 32'h204, 32'hCAFE_F00D);
      drain("t3b");

      // Starvation: continuous MEM traffic with a pending fetch
      mem_lat = 1;
      for (int k = 0; k < 3; k++) push_mem(1'b1, 1'b0, 32'h300 + 32'(k * 4), 32'h0);
      push_if(32'h48);
      for (int k = 0; k < 3; k++) push_mem(k[0], ~k[0], 32'h310 + 32'(k * 4), 32'h5000 + 32'(k));
      push_if(32'h4C);
      push_mem(1'b1, 1'b0, 32'h320, 32'h0);
      drain("t4");

      // Reset while MEM owns memory, then a late ack must be ignored
      mem_lat = 6;
      push_mem(1'b1, 1'b0, 32'h400, 32'h0);
      begin : wait_grant
         int n;
         n = 0;
         while (!ramreq && n < 20) begin @(negedge clk); n++; end
         chk("t5_granted", 64'(ramreq), 64'd1);
      end
      @(posedge clk); #3;
      rst = 1'b1;
      mem_q.delete(); sb.delete(); memrd = 1'b0; memwr = 1'b0;
      #1;
      chk("t5_ramreq_async", 64'(ramreq), 64'd0);
      chk("t5_memvalid_rst", 64'(memvalid), 64'd0);
      @(posedge clk); #3;
      rst = 1'b0;
      stray_ack = 1'b1;
      @(posedge clk); #3;
      chk("t5_late_ack_memvalid", 64'(memvalid), 64'd0);
      chk("t5_late_ack_ifvalid", 64'(ifvalid), 64'd0);
      @(posedge clk); #3;
      chk("t5_idle_ramreq", 64'(ramreq), 64'd0);
      mem_lat = 0;
      push_if(32'h80);
      drain("t5");

      // Stray ack in IDLE with no requesters
      repeat (2) @(negedge clk);
      stray_ack = 1'b1;
      @(posedge clk); #3;
      chk("t6_ifvalid", 64'(ifvalid), 64'd0);
      chk("t6_memvalid", 64'(memvalid), 64'd0);
      @(posedge clk); #3;
      chk("t6_ramreq", 64'(ramreq), 64'd0);
      mem_lat = 0;
      push_mem(1'b1, 1'b0, 32'h500, 32'h0);
      drain("t6");

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw).
- The memory uses a request/acknowledge protocol with variable latency.
- Generates per-stage stall signals so the pipeline controller can freeze PC/IR (WPCIR) or hold the MEM stage.
- Gives the MEM stage priority, and guarantees IF forward progress with a starvation counter.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 3, consecutive MEM grants allowed while IFREQ is pending before IF is forced to win; legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IFREQ  in  1  IF stage requests an instruction read.
- IFADDR  in  ADDR_W  fetch address (IFPC).
- IFRDATA  out  DATA_W  fetched instruction; valid only while IFVALID=1.
- IFVALID  out  1  IF transaction completes this cycle.
- STALLIF  out  1  IF must hold PC/IR this cycle.
- MEMRD  in  1  MEM stage load request.
- MEMWR  in  1  MEM stage store request.
- MEMADDR  in  ADDR_W  data address (EX ALU result).
- MEMWDATA  in  DATA_W  store data.
- MEMRDATA  out  DATA_W  load data; valid only while MEMVALID=1.
- MEMVALID  out  1  MEM transaction completes this cycle.
- STALLMEM  out  1  MEM stage must hold this cycle.
- RAMREQ  out  1  request to memory (registered).
- RAMWE  out  1  1=write, 0=read (registered).
- RAMADDR  out  ADDR_W  memory address (registered).
- RAMWDATA  out  DATA_W  memory write data (registered).
- RAMRDATA  in  DATA_W  memory read data; valid while RAMACK=1.
- RAMACK  in  1  one-cycle completion pulse from memory.

Behaviour:
- States: IDLE, BUSY_IF, BUSY_MEM.
- Reset (async, RST=1):
  - state=IDLE; starve count=0.
  - RAMREQ=0, RAMWE=0, RAMADDR=0, RAMWDATA=0.
  - IFVALID=0, MEMVALID=0.
  - STALLIF=IFREQ, STALLMEM=MEMRD|MEMWR (combinational outputs follow the rule below).
- IDLE, at the clock edge:
  - MEM request (MEMRD|MEMWR) wins unless IFREQ=1 and starve count=STARVE_MAX. In that case IF wins.
  - Winner's address/data/write-enable are registered onto the RAM* outputs; RAMREQ=1 from the next cycle.
  - Go to BUSY_MEM or BUSY_IF. No request: stay in IDLE, RAMREQ=0.
- BUSY_x:
  - RAM* outputs held stable until RAMACK.
  - On RAMACK=1: the owner's VALID=1 that same cycle (combinational, RAMACK & state).
  - IFRDATA/MEMRDATA = RAMRDATA pass-through.
  - At that edge: state to IDLE, RAMREQ to 0. Next grant is decided in IDLE the following cycle (one idle cycle between transactions).
- Minimum latency: request high at cycle 0 → RAMREQ cycle 1 → VALID cycle 1 if the memory acks in its first cycle.
- Stall outputs (combinational):
  - STALLIF = IFREQ & ~IFVALID.
  - STALLMEM = (MEMRD|MEMWR) & ~MEMVALID.
- Requesters hold request and operands stable until VALID. They may drop or change them at the edge ending the VALID cycle.
- MEMWR=1 with MEMRD=1: treated as a write. MEMVALID pulses on ack; MEMRDATA is don't-care.
- Starve count:
  - +1 (saturating at STARVE_MAX) at each MEM grant made while IFREQ=1.
  - Cleared to 0 on an IF grant, or in any cycle with IFREQ=0.
  - Width 4 bits.
- RAMACK in IDLE (e.g. a stale ack after reset mid-transaction): ignored; no VALID pulse.
- Reset mid-transaction: RAMREQ drops asynchronously; the transaction is abandoned; the memory must tolerate RAMREQ withdrawal.
- Requests that drop while the other port owns memory: no effect; the arbitration decision is taken only in IDLE.

Test Plan:
- Reset then single fetch: IFREQ=1, IFADDR=0x40, ack after 2 cycles with RAMRDATA=0x8C220004.
  → RAMREQ=1, RAMWE=0, RAMADDR=0x40.
  → IFVALID=1 for one cycle with IFRDATA=0x8C220004.
  → STALLIF=1 for all earlier request cycles.
- Simultaneous IFREQ and MEMRD (addr 0x100), immediate acks.
  → MEM granted first; MEMVALID pulse.
  → Next IDLE cycle IF granted; STALLIF=1 until its ack.
- Store: MEMWR=1, MEMADDR=0x200, MEMWDATA=0xDEADBEEF.
  → RAMWE=1, RAMWDATA=0xDEADBEEF, held until RAMACK; MEMVALID pulse; RAMREQ=0 the next cycle.
- Starvation, STARVE_MAX=3: MEM requests continuous with IFREQ=1.
  → Grants follow MEM,MEM,MEM,IF, then MEM resumes; count returns to 0 after the IF grant.
- Reset asserted while in BUSY_MEM with RAMACK pending.
  → RAMREQ=0 immediately; a late RAMACK gives no MEMVALID; state=IDLE.
- Stray RAMACK in IDLE with no requests → IFVALID=MEMVALID=0, state unchanged.
